adc_cfg_sequencer: RTL and testbench
====================================

Name: adc_cfg_sequencer

Overview:
- Master-side controller for the serial ADC command port (inputs en / sclk / in), whose byte type is decoded from its leading bits: setup 01xxxxxx, averaging 001xxxxx, conversion 1xxxxxxx.
- On a start request it writes the setup byte, then the averaging byte, then a programmable number of conversion bytes (or an unbounded stream).
- Generates the serial clock, frame enable and data from the system clock.
- Sits between the test/control logic and the ADC serial port.

Parameters:
- CLK_DIV, 4, system clocks per sclk half-period (legal values 1 and above).
- GAP_CYCLES, 8, idle system clocks between bytes, with adc_en low and adc_sclk low (legal values 1 and above).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle start request
- stop  in  1  one-cycle stop request (honoured at byte boundary)
- setup_cfg  in  6  setup payload; byte sent is {2'b01, setup_cfg}
- aver_cfg  in  5  averaging payload; byte sent is {3'b001, aver_cfg}
- conv_cfg  in  7  conversion payload; byte sent is {1'b1, conv_cfg}
- num_conv  in  16  number of conversion bytes; 0 = continuous until stop
- adc_sclk  out  1  serial clock, idles low
- adc_en  out  1  frame enable to ADC
- adc_din  out  1  serial data, MSB first
- busy  out  1  high from accepted start to end of last gap
- byte_done  out  1  one-cycle pulse after each byte's final falling sclk edge
- phase  out  2  byte in flight: 0 idle, 1 setup, 2 averaging, 3 conversion
- conv_count  out  16  conversion bytes completed since last start

Behaviour:
- Reset (async, immediate): FSM to IDLE; adc_sclk=0, adc_en=0, adc_din=0, busy=0, byte_done=0, phase=0, conv_count=0; all counters cleared.
  - Reset mid-byte truncates the frame. Known hazard: the ADC bit counter desyncs. Recovery is the caller's job: issue a full start sequence.
- FSM states: IDLE, LOAD, SHIFT, GAP.
- IDLE:
  - start=1 and stop=0 → LOAD. setup_cfg, aver_cfg, conv_cfg and num_conv are latched on that cycle.
  - Config input changes after that cycle have no effect until the next start.
  - start while busy is ignored. start with stop=1 in the same cycle is ignored (stop has priority).
- LOAD (1 cycle): select the byte for the current phase into the shift register; busy=1 from this cycle.
- SHIFT, per byte:
  - adc_en rises at entry with adc_din = bit7 and adc_sclk low.
  - Each bit is a low half-period then a high half-period, each CLK_DIV clocks.
  - adc_din changes only at the start of a low half, so it is stable across the rising edge.
  - Exactly 8 rising edges per frame, followed by the trailing falling edge (the ADC latches on it).
  - After the 8th high half, adc_sclk returns low, then byte_done pulses and adc_en drops in the same cycle → GAP.
  - Byte occupies exactly 16*CLK_DIV clocks with adc_en high.
- GAP: GAP_CYCLES clocks with adc_en=0 and adc_sclk=0, then the next-state decision:
  - after setup → averaging;
  - after averaging → conversion;
  - after conversion: conv_count += 1;
    - if stop is pending → IDLE;
    - else if num_conv != 0 and conv_count == num_conv → IDLE;
    - otherwise another conversion byte.
- stop: captured into a sticky pending flag whenever busy. It never aborts a byte; the current byte and its gap complete, then → IDLE.
  - A stop during setup or averaging still lets that byte finish, then → IDLE with no conversions.
  - The flag clears on entry to IDLE. stop while IDLE has no effect.
- conv_count saturates at 16'hFFFF in continuous mode. It is cleared on accepted start, and otherwise holds its value in IDLE.
- busy drops on the IDLE entry cycle. phase follows the byte in LOAD, SHIFT and GAP, and is 0 in IDLE.

Decomposition:
- Shared package adc_pkg holds:
  - prefixes: SETUP_PFX=2'b01, AVER_PFX=3'b001, CONV_PFX=1'b1;
  - phase encodings;
  - FSM state enum.
- Sub-module adc_spi_byte_tx contains the divider, the 3-bit bit counter and the shift register; it generates sclk/en/din and a done pulse from a load strobe plus an 8-bit byte.
- The top-level FSM handles sequencing, stop, count and config latching.

Test Plan:
- CLK_DIV=2, GAP_CYCLES=4, setup_cfg=6'h15, aver_cfg=5'h0A, conv_cfg=7'h23, num_conv=3, start pulse → bytes 8'h55, 8'h2A, 8'hA3 ×3 on adc_din. Each frame is 32 clocks of adc_en with 8 rising sclk edges; byte_done fires 5 times; conv_count=3; busy drops after the last gap. An ADC behavioural model ends with setup=55, aver=2A, conv=A3.
- num_conv=0, stop pulsed mid-way through the 4th conversion byte → 4th byte completes intact, then IDLE, conv_count=4, no partial frame.
- start re-pulsed while busy, and config inputs changed mid-sequence → ignored; the transmitted bytes still match the latched values.
- rst asserted mid-byte of the averaging frame → adc_en, adc_sclk, busy and phase drop to 0 asynchronously. A subsequent start re-sends 55, 2A, … correctly.
- start and stop high in the same IDLE cycle → no activity, busy stays 0.
- CLK_DIV=1, GAP_CYCLES=1 → sclk period is 2 clocks, byte frame 16 clocks, one idle clock between frames with adc_en low.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared encodings for the ADC command-port sequencer: byte prefixes, phases, FSM states.
package adc_pkg;

  localparam logic [1:0] SETUP_PFX = 2'b01;
  localparam logic [2:0] AVER_PFX  = 3'b001;
  localparam logic       CONV_PFX  = 1'b1;

  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_SETUP = 2'd1,
    PH_AVER  = 2'd2,
    PH_CONV  = 2'd3
  } phase_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_GAP
  } state_t;

  function automatic logic [7:0] cfg_byte(input phase_t ph, input logic [5:0] s,
                                          input logic [4:0] a, input logic [6:0] c);
    logic [7:0] b;
    case (ph)
      PH_SETUP: b = {SETUP_PFX, s};
      PH_AVER:  b = {AVER_PFX, a};
      PH_CONV:  b = {CONV_PFX, c};
      default:  b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/adc_spi_byte_tx.sv
// Serialises one byte MSB first: en high for 16*CLK_DIV clocks, sclk idles low,
// din changes only as sclk falls; sclk/en drop together and o_done pulses that cycle.
module adc_spi_byte_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [7:0] i_byte,
  output logic       o_sclk,
  output logic       o_en,
  output logic       o_din,
  output logic       o_done,
  output logic       o_last
);

  localparam int DW = $clog2(CLK_DIV + 1);

  logic [DW-1:0] r_div;
  logic [2:0]    r_bit;
  logic [6:0]    r_sh;
  logic          r_sclk;
  logic          r_en;
  logic          r_din;
  logic          r_done;
  logic          w_half_end;

  assign w_half_end = (r_div == DW'(CLK_DIV - 1));
  // final clock of the 8th high half; the owner uses it to leave SHIFT on the same edge en drops
  assign o_last     = r_en && r_sclk && w_half_end && (r_bit == 3'd7);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div  <= '0;
      r_bit  <= 3'd0;
      r_sh   <= 7'd0;
      r_sclk <= 1'b0;
      r_en   <= 1'b0;
      r_din  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_load) begin
        r_en   <= 1'b1;
        r_sclk <= 1'b0;
        r_din  <= i_byte[7];
        r_sh   <= i_byte[6:0];
        r_bit  <= 3'd0;
        r_div  <= '0;
      end else if (r_en) begin
        if (!w_half_end) begin
          r_div <= r_div + DW'(1);
        end else begin
          r_div <= '0;
          if (!r_sclk) begin
            r_sclk <= 1'b1;
          end else begin
            r_sclk <= 1'b0;
            if (r_bit == 3'd7) begin
              r_en   <= 1'b0;
              r_din  <= 1'b0;
              r_done <= 1'b1;
            end else begin
              r_din <= r_sh[6];
              r_sh  <= {r_sh[5:0], 1'b0};
              r_bit <= r_bit + 3'd1;
            end
          end
        end
      end
    end
  end

  assign o_sclk = r_sclk;
  assign o_en   = r_en;
  assign o_din  = r_din;
  assign o_done = r_done;

endmodule

// File: rtl/adc_cfg_sequencer.sv
// Sequences setup, averaging and N (or endless) conversion bytes to the ADC command port.
// Stop is sticky while busy and only acts at the end of a byte's gap.
module adc_cfg_sequencer #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic [5:0]  setup_cfg,
  input  logic [4:0]  aver_cfg,
  input  logic [6:0]  conv_cfg,
  input  logic [15:0] num_conv,
  output logic        adc_sclk,
  output logic        adc_en,
  output logic        adc_din,
  output logic        busy,
  output logic        byte_done,
  output logic [1:0]  phase,
  output logic [15:0] conv_count
);

  import adc_pkg::*;

  localparam int GW = $clog2(GAP_CYCLES + 1);

  state_t        r_state, w_next_state;
  phase_t        r_phase, w_next_phase;
  logic [GW-1:0] r_gap;
  logic          r_stop_pend;
  logic [5:0]    r_setup;
  logic [4:0]    r_aver;
  logic [6:0]    r_conv;
  logic [15:0]   r_num;
  logic [15:0]   r_conv_cnt;

  logic          w_accept;
  logic          w_gap_end;
  logic          w_stop_any;
  logic          w_load;
  logic          w_last;
  logic          w_cnt_inc;
  logic [15:0]   w_cnt_nxt;
  logic [7:0]    w_byte;

  assign w_accept   = (r_state == ST_IDLE) && start && !stop;
  assign w_gap_end  = (r_state == ST_GAP) && (r_gap == GW'(GAP_CYCLES - 1));
  assign w_stop_any = r_stop_pend | stop;
  assign w_cnt_nxt  = (r_conv_cnt == 16'hFFFF) ? r_conv_cnt : r_conv_cnt + 16'd1;
  assign w_byte     = cfg_byte(w_next_phase, r_setup, r_aver, r_conv);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // The last gap clock loads the next byte directly, so frames are separated by exactly GAP_CYCLES.
  always_comb begin
    w_next_state = r_state;
    w_next_phase = r_phase;
    w_load       = 1'b0;
    w_cnt_inc    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next_state = ST_LOAD;
          w_next_phase = PH_SETUP;
        end
      end
      ST_LOAD: begin
        w_load       = 1'b1;
        w_next_state = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_last) w_next_state = ST_GAP;
      end
      ST_GAP: begin
        if (w_gap_end) begin
          w_next_state = ST_SHIFT;
          w_load       = 1'b1;
          case (r_phase)
            PH_SETUP: w_next_phase = PH_AVER;
            PH_AVER:  w_next_phase = PH_CONV;
            default:  w_cnt_inc    = 1'b1;
          endcase
          if (w_stop_any ||
              (r_phase == PH_CONV && r_num != 16'd0 && w_cnt_nxt == r_num)) begin
            w_next_state = ST_IDLE;
            w_next_phase = PH_IDLE;
            w_load       = 1'b0;
          end
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_phase = PH_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase     <= PH_IDLE;
      r_gap       <= '0;
      r_stop_pend <= 1'b0;
      r_setup     <= 6'd0;
      r_aver      <= 5'd0;
      r_conv      <= 7'd0;
      r_num       <= 16'd0;
      r_conv_cnt  <= 16'd0;
    end else begin
      r_phase <= w_next_phase;
      if (r_state == ST_GAP) r_gap <= r_gap + GW'(1);
      else                   r_gap <= '0;
      if (w_next_state == ST_IDLE)              r_stop_pend <= 1'b0;
      else if (r_state != ST_IDLE && stop)      r_stop_pend <= 1'b1;
      if (w_accept) begin
        r_setup    <= setup_cfg;
        r_aver     <= aver_cfg;
        r_conv     <= conv_cfg;
        r_num      <= num_conv;
        r_conv_cnt <= 16'd0;
      end else if (w_cnt_inc) begin
        r_conv_cnt <= w_cnt_nxt;
      end
    end
  end

  adc_spi_byte_tx #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_byte (w_byte),
    .o_sclk (adc_sclk),
    .o_en   (adc_en),
    .o_din  (adc_din),
    .o_done (byte_done),
    .o_last (w_last)
  );

  assign busy       = (r_state != ST_IDLE);
  assign phase      = r_phase;
  assign conv_count = r_conv_cnt;

endmodule

// File: tb/tb_adc_cfg_sequencer.sv
// Directed bench: two sequencer instances (CLK_DIV=2/GAP=4 and CLK_DIV=1/GAP=1) observed by one ADC model.
module tb_adc_cfg_sequencer;

  logic        clk = 1'b0;
  logic        rst, start0, start1, stop;
  logic [5:0]  setup_cfg;
  logic [4:0]  aver_cfg;
  logic [6:0]  conv_cfg;
  logic [15:0] num_conv;

  logic        sclk0, en0, din0, busy0, done0;
  logic [1:0]  phase0;
  logic [15:0] cnt0;
  logic        sclk1, en1, din1, busy1, done1;
  logic [1:0]  phase1;
  logic [15:0] cnt1;

  always #5 clk = ~clk;

  adc_cfg_sequencer #(.CLK_DIV(2), .GAP_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start0), .stop(stop),
    .setup_cfg(setup_cfg), .aver_cfg(aver_cfg), .conv_cfg(conv_cfg), .num_conv(num_conv),
    .adc_sclk(sclk0), .adc_en(en0), .adc_din(din0), .busy(busy0), .byte_done(done0),
    .phase(phase0), .conv_count(cnt0)
  );

  adc_cfg_sequencer #(.CLK_DIV(1), .GAP_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .stop(stop),
    .setup_cfg(setup_cfg), .aver_cfg(aver_cfg), .conv_cfg(conv_cfg), .num_conv(num_conv),
    .adc_sclk(sclk1), .adc_en(en1), .adc_din(din1), .busy(busy1), .byte_done(done1),
    .phase(phase1), .conv_count(cnt1)
  );

  // ADC behavioural model on whichever instance sel picks
  logic sel = 1'b0;
  logic mon_clr = 1'b0;
  logic m_en, m_sclk, m_din, m_done, m_busy;
  assign m_en   = sel ? en1   : en0;
  assign m_sclk = sel ? sclk1 : sclk0;
  assign m_din  = sel ? din1  : din0;
  assign m_done = sel ? done1 : done0;
  assign m_busy = sel ? busy1 : busy0;

  logic [7:0] q_byte[$];
  int         q_rise[$], q_len[$], q_gap[$];
  int         done_cnt, din_bad, sclk_bad;
  logic [7:0] adc_setup, adc_aver, adc_conv;
  logic [7:0] exp_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  initial begin
    logic       prev_en, prev_sclk, prev_din, m_seen;
    logic [7:0] m_sh;
    int         m_cnt, m_rise, m_idle;
    prev_en = 0; prev_sclk = 0; prev_din = 0; m_seen = 0;
    m_sh = 0; m_cnt = 0; m_rise = 0; m_idle = 0;
    done_cnt = 0; din_bad = 0; sclk_bad = 0;
    adc_setup = 0; adc_aver = 0; adc_conv = 0;
    forever begin
      @(negedge clk);
      if (mon_clr) begin
        q_byte.delete(); q_rise.delete(); q_len.delete(); q_gap.delete();
        done_cnt = 0; din_bad = 0; sclk_bad = 0; m_seen = 0; m_idle = 0;
        adc_setup = 0; adc_aver = 0; adc_conv = 0;
      end else begin
        if (m_done) done_cnt++;
        if (!m_en && m_sclk) sclk_bad++;
        if (m_en && prev_en && m_sclk && m_din !== prev_din) din_bad++;
        if (m_en && !prev_en) begin
          if (m_seen) q_gap.push_back(m_idle);
          m_cnt = 0; m_rise = 0; m_sh = 0;
        end
        if (m_en) begin
          m_cnt++;
          if (m_sclk && !prev_sclk) begin
            m_sh = {m_sh[6:0], m_din};
            m_rise++;
          end
        end else begin
          m_idle++;
        end
        if (!m_en && prev_en) begin
          q_byte.push_back(m_sh); q_rise.push_back(m_rise); q_len.push_back(m_cnt);
          m_seen = 1; m_idle = 1;
          if (m_rise == 8) begin
            if (m_sh[7])      adc_conv  = m_sh;
            else if (m_sh[6]) adc_setup = m_sh;
            else if (m_sh[5]) adc_aver  = m_sh;
          end
        end
      end
      prev_en = m_en; prev_sclk = m_sclk; prev_din = m_din;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic flush();
    #1 mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int i;
    i = 0;
    while (m_busy && i < max) begin
      @(negedge clk);
      i++;
    end
    check({tag, " idle-timeout"}, 32'(i < max), 1);
  endtask

  task automatic check_frames(input string tag, input int len, input int gap);
    check({tag, " nframes"}, q_byte.size(), exp_q.size());
    for (int i = 0; i < q_byte.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s byte%0d", tag, i), q_byte[i], exp_q[i]);
      check($sformatf("%s rises%0d", tag, i), q_rise[i], 8);
      check($sformatf("%s len%0d", tag, i), q_len[i], len);
    end
    for (int i = 0; i < q_gap.size(); i++)
      check($sformatf("%s gap%0d", tag, i), q_gap[i], gap);
    check({tag, " byte_done"}, done_cnt, exp_q.size());
    check({tag, " din_stable"}, din_bad, 0);
    check({tag, " sclk_idle"}, sclk_bad, 0);
  endtask

  task automatic pulse_start0();
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
  endtask

  initial begin
    int i;
    rst = 1'b1; start0 = 0; start1 = 0; stop = 0;
    setup_cfg = 6'h15; aver_cfg = 5'h0A; conv_cfg = 7'h23; num_conv = 16'd3;
    cycles(3);
    check("rst sclk", sclk0, 0);
    check("rst en", en0, 0);
    check("rst din", din0, 0);
    check("rst busy", busy0, 0);
    check("rst done", done0, 0);
    check("rst phase", phase0, 0);
    check("rst count", cnt0, 0);
    rst = 1'b0;
    cycles(2);
    flush();

    // bounded sequence of three conversions
    pulse_start0();
    check("t1 busy", busy0, 1);
    check("t1 phase", phase0, 1);
    wait_idle("t1", 1000);
    exp_q = '{8'h55, 8'h2A, 8'hA3, 8'hA3, 8'hA3};
    check_frames("t1", 32, 4);
    check("t1 count", cnt0, 3);
    check("t1 phase_idle", phase0, 0);
    check("t1 adc_setup", adc_setup, 8'h55);
    check("t1 adc_aver", adc_aver, 8'h2A);
    check("t1 adc_conv", adc_conv, 8'hA3);
    cycles(5);
    check("t1 count_hold", cnt0, 3);
    flush();

    // continuous mode, stop during the 4th conversion byte
    setup_cfg = 6'h3F; aver_cfg = 5'h11; conv_cfg = 7'h5C; num_conv = 16'd0;
    pulse_start0();
    check("t2 count_clr", cnt0, 0);
    i = 0;
    while (!(q_byte.size() == 5 && m_en) && i < 2000) begin
      @(negedge clk);
      i++;
    end
    check("t2 reach4th", 32'(i < 2000), 1);
    cycles(10);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("t2 still_en", en0, 1);
    wait_idle("t2", 1000);
    exp_q = '{8'h7F, 8'h31, 8'hDC, 8'hDC, 8'hDC, 8'hDC};
    check_frames("t2", 32, 4);
    check("t2 count", cnt0, 4);
    flush();

    // restart while busy and config changes after latching are ignored
    setup_cfg = 6'h15; aver_cfg = 5'h0A; conv_cfg = 7'h23; num_conv = 16'd2;
    pulse_start0();
    cycles(40);
    setup_cfg = 6'h00; aver_cfg = 5'h1F; conv_cfg = 7'h00; num_conv = 16'd5;
    pulse_start0();
    wait_idle("t3", 1000);
    exp_q = '{8'h55, 8'h2A, 8'hA3, 8'hA3};
    check_frames("t3", 32, 4);
    check("t3 count", cnt0, 2);
    flush();

    // asynchronous reset in the middle of the averaging frame
    setup_cfg = 6'h15; aver_cfg = 5'h0A; conv_cfg = 7'h23; num_conv = 16'd1;
    pulse_start0();
    i = 0;
    while (!(phase0 == 2'd2 && en0) && i < 500) begin
      @(negedge clk);
      i++;
    end
    check("t4 reach_aver", 32'(i < 500), 1);
    cycles(5);
    #1 rst = 1'b1;
    #1;
    check("t4 en_async", en0, 0);
    check("t4 sclk_async", sclk0, 0);
    check("t4 busy_async", busy0, 0);
    check("t4 phase_async", phase0, 0);
    cycles(2);
    rst = 1'b0;
    cycles(2);
    flush();
    pulse_start0();
    wait_idle("t4", 1000);
    exp_q = '{8'h55, 8'h2A, 8'hA3};
    check_frames("t4", 32, 4);
    check("t4 count", cnt0, 1);
    check("t4 adc_aver", adc_aver, 8'h2A);
    flush();

    // start and stop in the same idle cycle
    start0 = 1'b1; stop = 1'b1;
    @(negedge clk);
    start0 = 1'b0; stop = 1'b0;
    check("t5 busy", busy0, 0);
    cycles(20);
    check("t5 busy_later", busy0, 0);
    check("t5 frames", q_byte.size(), 0);
    flush();

    // minimum divider and gap
    sel = 1'b1;
    setup_cfg = 6'h15; aver_cfg = 5'h0A; conv_cfg = 7'h23; num_conv = 16'd2;
    cycles(1);
    flush();
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("t6 busy", busy1, 1);
    wait_idle("t6", 500);
    exp_q = '{8'h55, 8'h2A, 8'hA3, 8'hA3};
    check_frames("t6", 16, 1);
    check("t6 ngaps", q_gap.size(), 3);
    check("t6 count", cnt1, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global-timeout: simulation did not finish, limit 2000000 ns");
    $fatal(1, "timeout");
  end

endmodule
